// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage with variable-latency dmem handshake, stall generation and MEM/WB register
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              Regwrite_Mem,
    input  logic              Memread_Mem,
    input  logic              Memwrite_Mem,
    input  logic [DATA_W-1:0] write_data_Mem,
    input  logic [DATA_W-1:0] store_data_Mem,
    input  logic [REG_W-1:0]  Mem_rd,
    input  logic              flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              stall_out,
    output logic              WB_valid,
    output logic              Regwrite_WB,
    output logic [REG_W-1:0]  WB_rd,
    output logic [DATA_W-1:0] WB_data,
    output logic              exc_misalign,
    output logic              exc_timeout
);
    typedef enum logic {IDLE, WAIT} state_t;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          mem_op, aligned, access, misalign, timeout_hit, timeout_exc, wb_v, is_load;

    assign aligned     = write_data_Mem[1:0] == 2'b00;
    assign mem_op      = in_valid & (Memread_Mem | Memwrite_Mem);
    assign access      = mem_op & aligned;
    assign misalign    = mem_op & ~aligned;
    assign is_load     = Memread_Mem & ~Memwrite_Mem;
    assign timeout_hit = (state == WAIT) & (cnt == CW'(TIMEOUT - 1));
    assign timeout_exc = timeout_hit & ~dmem_ready;
    assign wb_v        = in_valid & ~flush;

    // Gated by rst_n so a reset mid-access drops the request even while inputs still ask for one
    assign dmem_req   = rst_n & (((state == IDLE) & access) | (state == WAIT));
    assign dmem_we    = Memwrite_Mem;
    assign dmem_addr  = write_data_Mem;
    assign dmem_wdata = store_data_Mem;
    assign stall_out  = dmem_req & ~dmem_ready & ~timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            WB_valid     <= 1'b0;
            Regwrite_WB  <= 1'b0;
            WB_rd        <= '0;
            WB_data      <= '0;
            exc_misalign <= 1'b0;
            exc_timeout  <= 1'b0;
        end else begin
            state        <= (state == IDLE) ? ((access & ~dmem_ready) ? WAIT : IDLE)
                                            : ((dmem_ready | timeout_hit) ? IDLE : WAIT);
            cnt          <= (state == WAIT) ? cnt + 1'b1 : '0;
            WB_valid     <= ~stall_out & wb_v;
            Regwrite_WB  <= ~stall_out & wb_v & Regwrite_Mem & ~Memwrite_Mem & ~misalign & ~timeout_exc;
            exc_misalign <= wb_v & misalign;
            exc_timeout  <= wb_v & timeout_exc;
            if (!stall_out) begin
                WB_rd   <= Mem_rd;
                WB_data <= is_load ? dmem_rdata : write_data_Mem;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed vectors with hand-computed expectations for mem_stage_ctrl
module tb_mem_stage_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, Regwrite_Mem = 0, Memread_Mem = 0, Memwrite_Mem = 0, flush = 0;
    logic [31:0] write_data_Mem = 0, store_data_Mem = 0, dmem_rdata = 0;
    logic [4:0]  Mem_rd = 0;
    logic        dmem_ready = 0;
    logic        dmem_req, dmem_we, stall_out, WB_valid, Regwrite_WB, exc_misalign, exc_timeout;
    logic [31:0] dmem_addr, dmem_wdata, WB_data;
    logic [4:0]  WB_rd;
    int          n_chk = 0, n_pass = 0;

    mem_stage_ctrl #(.DATA_W(32), .REG_W(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .Regwrite_Mem(Regwrite_Mem),
        .Memread_Mem(Memread_Mem), .Memwrite_Mem(Memwrite_Mem), .write_data_Mem(write_data_Mem),
        .store_data_Mem(store_data_Mem), .Mem_rd(Mem_rd), .flush(flush), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .stall_out(stall_out), .WB_valid(WB_valid), .Regwrite_WB(Regwrite_WB),
        .WB_rd(WB_rd), .WB_data(WB_data), .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic v, input logic rw, input logic rd_, input logic wr,
                      input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
        in_valid = v; Regwrite_Mem = rw; Memread_Mem = rd_; Memwrite_Mem = wr;
        write_data_Mem = a; store_data_Mem = sd; Mem_rd = r;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_wbv", WB_valid, 0);
        rst_n = 1;
        tick();
        chk("idle_req", dmem_req, 0);
        chk("idle_stall", stall_out, 0);
        chk("idle_wb", {WB_valid, Regwrite_WB, exc_misalign, exc_timeout}, 0);
        chk("idle_data", WB_data, 0);

        op(1, 1, 0, 0, 32'h1234, 0, 7);
        #1;
        chk("alu_req", dmem_req, 0);
        chk("alu_stall", stall_out, 0);
        tick();
        chk("alu_wbv", WB_valid, 1);
        chk("alu_rw", Regwrite_WB, 1);
        chk("alu_rd", WB_rd, 7);
        chk("alu_data", WB_data, 32'h1234);

        op(1, 1, 1, 0, 32'h100, 0, 9);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ld_req_wait", dmem_req, 1);
            chk("ld_stall", stall_out, 1);
            tick();
            chk("ld_bubble", {WB_valid, Regwrite_WB}, 0);
        end
        dmem_ready = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_req_last", dmem_req, 1);
        chk("ld_stall_rel", stall_out, 0);
        tick();
        chk("ld_wbv", WB_valid, 1);
        chk("ld_rw", Regwrite_WB, 1);
        chk("ld_rd", WB_rd, 9);
        chk("ld_data", WB_data, 32'hDEADBEEF);

        op(1, 0, 0, 1, 32'h204, 32'h55, 3);
        #1;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h204);
        chk("st_wdata", dmem_wdata, 32'h55);
        chk("st_stall", stall_out, 0);
        tick();
        dmem_ready = 0;
        chk("st_wbv", WB_valid, 1);
        chk("st_rw", Regwrite_WB, 0);

        op(1, 1, 1, 0, 32'h102, 0, 4);
        #1;
        chk("mis_req", dmem_req, 0);
        chk("mis_stall", stall_out, 0);
        tick();
        chk("mis_exc", exc_misalign, 1);
        chk("mis_rw", Regwrite_WB, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("mis_pulse_end", exc_misalign, 0);

        op(1, 1, 0, 0, 32'h40, 0, 5);
        flush = 1;
        tick();
        flush = 0;
        chk("flush_wbv", WB_valid, 0);
        chk("flush_rw", Regwrite_WB, 0);

        op(1, 1, 1, 0, 32'h200, 0, 6);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("to_stall", stall_out, 1);
            tick();
            chk("to_bubble", WB_valid, 0);
        end
        #1;
        chk("to_stall_rel", stall_out, 0);
        chk("to_req_last", dmem_req, 1);
        tick();
        chk("to_exc", exc_timeout, 1);
        chk("to_rw", Regwrite_WB, 0);
        chk("to_wbv", WB_valid, 1);
        op(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("to_pulse_end", exc_timeout, 0);
        chk("to_idle_req", dmem_req, 0);

        op(1, 1, 1, 0, 32'h300, 0, 8);
        tick();
        tick();
        #1;
        chk("rmid_req_pre", dmem_req, 1);
        rst_n = 0;
        #1;
        chk("rmid_req", dmem_req, 0);
        chk("rmid_stall", stall_out, 0);
        op(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1;
        tick();
        chk("rmid_wbv", WB_valid, 0);
        chk("rmid_rw", Regwrite_WB, 0);
        chk("rmid_req_after", dmem_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register; consumes its Regwrite_Mem, write_data_Mem and Mem_rd outputs plus memory-control fields.
- Drives a variable-latency data-memory request/ready handshake and registers the MEM/WB pipeline outputs.
- Raises stall_out so upstream stages hold while an access is outstanding.
- Flags misaligned accesses and memory timeouts.

Parameters:
- DATA_W, 32, data/address width.
- REG_W, 5, register-index width.
- TIMEOUT, 16, maximum WAIT cycles before abandoning an access (must be >= 2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  EX/MEM slot holds a real instruction.
- Regwrite_Mem  in  1  instruction writes the register file.
- Memread_Mem  in  1  load.
- Memwrite_Mem  in  1  store.
- write_data_Mem  in  DATA_W  ALU result; load/store address.
- store_data_Mem  in  DATA_W  store value.
- Mem_rd  in  REG_W  destination register.
- flush  in  1  kill writeback of the instruction completing this cycle.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write enable; valid with dmem_req.
- dmem_addr  out  DATA_W  address (= write_data_Mem).
- dmem_wdata  out  DATA_W  store data.
- dmem_ready  in  1  memory completes the access this cycle.
- dmem_rdata  in  DATA_W  load data; valid with dmem_ready.
- stall_out  out  1  hold EX/MEM and earlier stages.
- WB_valid  out  1  registered: MEM/WB slot valid.
- Regwrite_WB  out  1  registered: write enable to the register file.
- WB_rd  out  REG_W  registered: destination register.
- WB_data  out  DATA_W  registered: writeback value.
- exc_misalign  out  1  registered 1-cycle pulse.
- exc_timeout  out  1  registered 1-cycle pulse.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, wait counter=0.
  - All registered outputs = 0.
  - dmem_req=0, stall_out=0.
  - Reset mid-access drops the request immediately; no writeback occurs.
- Definitions:
  - access = in_valid & (Memread_Mem | Memwrite_Mem) & aligned.
  - aligned = (write_data_Mem[1:0]==0).
  - If Memread_Mem and Memwrite_Mem are both high, Memwrite_Mem takes priority.
- Combinational memory outputs:
  - dmem_req = (IDLE & access) | WAIT.
  - dmem_we = Memwrite_Mem.
  - dmem_addr / dmem_wdata pass straight through. Inputs stay stable because upstream is held by stall_out.
- stall_out = dmem_req & ~dmem_ready & ~timeout_hit.
  - timeout_hit = WAIT & (counter == TIMEOUT-1).
  - Zero-wait access (dmem_req and dmem_ready in the same IDLE cycle): no stall, completes in 1 cycle.
- FSM:
  - IDLE to WAIT: access & ~dmem_ready. Counter loads 0.
  - WAIT to WAIT: ~dmem_ready & ~timeout_hit. Counter increments.
  - WAIT to IDLE: dmem_ready, normal completion.
  - WAIT to IDLE: timeout_hit & ~dmem_ready, abandoned.
  - dmem_ready on the same cycle as timeout_hit counts as normal completion.
- MEM/WB register update at each posedge:
  - Completion cycle (non-memory valid op, misaligned op, ready in IDLE or WAIT, or timeout):
    - WB_valid = in_valid & ~flush.
    - WB_rd = Mem_rd.
    - WB_data = Memread_Mem ? dmem_rdata : write_data_Mem.
    - Regwrite_WB = WB_valid & Regwrite_Mem & ~Memwrite_Mem & no exception.
  - Stall cycle: insert a bubble (WB_valid=0, Regwrite_WB=0). WB_rd and WB_data are don't-care but hold their previous values.
  - in_valid=0: bubble.
- Exceptions:
  - Misaligned memory op: no dmem_req, exc_misalign=1 for one cycle, Regwrite_WB=0, no stall.
  - Timeout: exc_timeout=1 for one cycle, Regwrite_WB=0.
  - flush suppresses exception pulses for the flushed instruction.
- flush during WAIT does not cancel the bus transaction. It only suppresses the writeback and exceptions in the completion cycle, and only if flush is high in that cycle.
- Back-to-back accesses: a new access may issue in the IDLE cycle directly after completion. No dead cycle is required.

Test Plan:
- Reset held, then released with in_valid=0 -> all outputs 0, stall_out=0, dmem_req=0.
- ALU op: Regwrite=1, rd=7, data=0x1234 -> next cycle WB_valid=1, Regwrite_WB=1, WB_rd=7, WB_data=0x1234, no stall.
- Load addr 0x100, ready after 3 cycles, rdata=0xDEADBEEF, rd=9 ->
  - stall_out=1 for 3 cycles, dmem_req held for 4 cycles.
  - WB bubbles during the stall.
  - Then WB_data=0xDEADBEEF, WB_rd=9, Regwrite_WB=1.
- Store addr 0x204, data 0x55, zero-wait ready -> dmem_we=1 for one cycle, no stall, WB_valid=1, Regwrite_WB=0.
- Load addr 0x102 -> no dmem_req, exc_misalign pulse, Regwrite_WB=0.
- Load with dmem_ready never asserted, TIMEOUT=16 -> stall releases after 16 cycles, exc_timeout pulse, Regwrite_WB=0, FSM back to IDLE.
- Reset asserted mid-WAIT -> dmem_req and stall_out drop asynchronously; no writeback after release.
